pipe_shifter: RTL

//  Parametrised, pipelined barrel shifter for the multi-cycle/pipelined datapath.

---
 rtl/shifter_pkg.sv | 43 ++++
 rtl/shifter_stage.sv | 94 +++++++++
 rtl/pipe_shifter.sv | 68 ++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared op codes and level-to-slice split for the pipelined barrel shifter.
// Rotate codes only take effect when PIPE_SHIFTER_ROTATE_EN is defined.
package shifter_pkg;

    typedef logic [2:0] shift_op_t;

    localparam shift_op_t OP_SLL = 3'b000;
    localparam shift_op_t OP_SRL = 3'b001;
    localparam shift_op_t OP_SRA = 3'b011;
    localparam shift_op_t OP_ROL = 3'b100;
    localparam shift_op_t OP_ROR = 3'b101;

    // Slices take ceil(saw/stages) levels each in ascending order; late slices may get fewer or none.
    function automatic int levels_in_stage(input int i, input int saw, input int stages);
        int per;
        int lo;
        int n;
        per = (saw + stages - 1) / stages;
        lo  = i * per;
        if (lo >= saw) begin
            n = 0;
        end else if (saw - lo < per) begin
            n = saw - lo;
        end else begin
            n = per;
        end
        return n;
    endfunction

    function automatic int first_level(input int i, input int saw, input int stages);
        int per;
        int lo;
        per = (saw + stages - 1) / stages;
        lo  = i * per;
        if (lo > saw) begin
            lo = saw;
        end else begin
            lo = lo;
        end
        return lo;
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// One register slice of pipe_shifter: mux levels LVL_LO..LVL_HI followed by a valid/ready register.
// Rotate levels are built only when PIPE_SHIFTER_ROTATE_EN is defined.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SAW    = 5,
    parameter int LVL_LO = 0,
    parameter int LVL_HI = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SAW-1:0]   in_sa,
    input  shift_op_t        in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SAW-1:0]   out_sa,
    output shift_op_t        out_op
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SAW-1:0]   sa_q, sa_d;
    shift_op_t        op_q, op_d;
    logic [WIDTH-1:0] shifted_s;

    // Mux levels owned by this slice; an empty range gives a plain register slice
    always_comb begin
        shifted_s = in_data;
        for (int k = LVL_LO; k <= LVL_HI; k++) begin
            if (in_sa[k]) begin
                case (in_op)
                    OP_SLL:  shifted_s = shifted_s << (1 << k);
                    OP_SRL:  shifted_s = shifted_s >> (1 << k);
                    OP_SRA:  shifted_s = $signed(shifted_s) >>> (1 << k);
`ifdef PIPE_SHIFTER_ROTATE_EN
                    OP_ROL:  shifted_s = (shifted_s << (1 << k)) | (shifted_s >> (WIDTH - (1 << k)));
                    OP_ROR:  shifted_s = (shifted_s >> (1 << k)) | (shifted_s << (WIDTH - (1 << k)));
`endif
                    default: shifted_s = shifted_s;
                endcase
            end else begin
                shifted_s = shifted_s;
            end
        end
    end

    assign in_ready = !valid_q || out_ready;

    // Slice update: load on accept, drain when the consumer takes the result, otherwise hold
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sa_d    = sa_q;
        op_d    = op_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = shifted_s;
                sa_d   = in_sa;
                op_d   = in_op;
            end else begin
                data_d = data_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Slice registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= {WIDTH{1'b0}};
            sa_q    <= {SAW{1'b0}};
            op_q    <= 3'b000;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sa_q    <= sa_d;
            op_q    <= op_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sa    = sa_q;
    assign out_op    = op_q;

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter: STAGES slices of shifter_stage with ready chained backwards.
// Define PIPE_SHIFTER_ROTATE_EN to build ROL/ROR; otherwise those codes pass the operand through.
module pipe_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int STAGES = 2,
    localparam int SAW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SAW-1:0]   in_sa,
    input  shift_op_t        in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    logic             valid_s [STAGES+1];
    logic             ready_s [STAGES+1];
    logic [WIDTH-1:0] data_s  [STAGES+1];
    logic [SAW-1:0]   sa_s    [STAGES+1];
    shift_op_t        op_s    [STAGES+1];

    assign valid_s[0]      = in_valid;
    assign data_s[0]       = in_data;
    assign sa_s[0]         = in_sa;
    assign op_s[0]         = in_op;
    assign ready_s[STAGES] = out_ready;
    assign in_ready        = ready_s[0];
    assign out_valid       = valid_s[STAGES];
    assign out_data        = data_s[STAGES];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        shifter_stage #(
            .WIDTH  (WIDTH),
            .SAW    (SAW),
            .LVL_LO (first_level(i, SAW, STAGES)),
            .LVL_HI (first_level(i, SAW, STAGES) + levels_in_stage(i, SAW, STAGES) - 1)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (valid_s[i]),
            .in_ready  (ready_s[i]),
            .in_data   (data_s[i]),
            .in_sa     (sa_s[i]),
            .in_op     (op_s[i]),
            .out_valid (valid_s[i+1]),
            .out_ready (ready_s[i+1]),
            .out_data  (data_s[i+1]),
            .out_sa    (sa_s[i+1]),
            .out_op    (op_s[i+1])
        );
    end

    // Any slice holding an op
    always_comb begin
        busy = 1'b0;
        for (int i = 1; i <= STAGES; i++) begin
            busy = busy | valid_s[i];
        end
    end

endmodule
